// File: rtl/accumulator_deskew.sv
// rtl/accumulator_deskew.sv - per-lane skew delay lines feeding an aligned-row FIFO with batch row counting
// Optional ALIGN_CHECK_EN adds the sticky skew_err output and drops misaligned rows.
module accumulator_deskew #(
    parameter int N_COLS     = 4,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_COLS-1:0]          valid_in,
    input  logic [N_COLS*DATA_W-1:0]   raw_data,
    input  logic                       out_ready,
    output logic                       aligned_valid,
    output logic [N_COLS*DATA_W-1:0]   aligned_data,
    output logic [CNT_W-1:0]           row_count,
    output logic                       batch_done,
`ifdef ALIGN_CHECK_EN
    output logic                       skew_err,
`endif
    output logic                       overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW1 = AW + 1;

    logic [N_COLS-1:0]        w_dv;
    logic [N_COLS*DATA_W-1:0] w_dd;

    // Lane c waits N_COLS-1-c cycles so it meets the last (undelayed) lane.
    for (genvar c = 0; c < N_COLS; c++) begin : g_lane
        localparam int D = N_COLS - 1 - c;
        if (D == 0) begin : g_thru
            assign w_dv[c]                    = valid_in[c];
            assign w_dd[c*DATA_W +: DATA_W]   = raw_data[c*DATA_W +: DATA_W];
        end else begin : g_dly
            logic [D-1:0]      r_v;
            logic [DATA_W-1:0] r_d [D];
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v <= '0;
                    for (int k = 0; k < D; k++) r_d[k] <= '0;
                end else begin
                    r_v[0] <= valid_in[c];
                    r_d[0] <= raw_data[c*DATA_W +: DATA_W];
                    for (int k = 1; k < D; k++) begin
                        r_v[k] <= r_v[k-1];
                        r_d[k] <= r_d[k-1];
                    end
                end
            end
            assign w_dv[c]                  = r_v[D-1];
            assign w_dd[c*DATA_W +: DATA_W] = r_d[D-1];
        end
    end

    logic w_fire;
    logic w_push_req;
    assign w_fire = w_dv[0];

`ifdef ALIGN_CHECK_EN
    logic w_all;
    logic w_skew;
    logic r_skew_err;
    assign w_all      = &w_dv;
    assign w_push_req = w_fire & w_all;
    assign w_skew     = (w_fire & ~w_all) | ((|(w_dv >> 1)) & ~w_fire);
    assign skew_err   = r_skew_err;
    always_ff @(posedge clk) begin
        if (reset)       r_skew_err <= 1'b0;
        else if (w_skew) r_skew_err <= 1'b1;
    end
`else
    assign w_push_req = w_fire;
`endif

    logic [N_COLS*DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [CW1-1:0]           r_count;
    logic                     r_overflow;
    logic                     r_prev_fire;
    logic [CNT_W-1:0]         r_row_count;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_batch_end;

    assign w_full      = (r_count == CW1'(FIFO_DEPTH));
    assign w_pop       = (r_count != '0) && out_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;
    assign w_batch_end = r_prev_fire && !w_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_prev_fire <= 1'b0;
            r_row_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dd;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW1'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW1'(1);
            if (w_drop) r_overflow <= 1'b1;
            r_prev_fire <= w_fire;
            if (w_batch_end)  r_row_count <= CNT_W'(w_push);
            else if (w_push)  r_row_count <= r_row_count + CNT_W'(1);
        end
    end

    assign aligned_valid = (r_count != '0);
    assign aligned_data  = r_mem[r_rd_ptr];
    assign row_count     = r_row_count;
    assign batch_done    = w_batch_end;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_accumulator_deskew.sv
// tb/tb_accumulator_deskew.sv - scoreboard bench for accumulator_deskew with a row-level reference model
module tb_accumulator_deskew;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int DEP  = 4;
    localparam int CW   = 8;
    localparam int NCY  = 1500;
    localparam int MAXR = 1500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             out_ready;
    logic [N-1:0]     valid_in;
    logic [N*W-1:0]   raw_data;
    logic             aligned_valid;
    logic [N*W-1:0]   aligned_data;
    logic [CW-1:0]    row_count;
    logic             batch_done;
    logic             overflow;
`ifdef ALIGN_CHECK_EN
    logic             skew_err;
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    accumulator_deskew #(.N_COLS(N), .DATA_W(W), .FIFO_DEPTH(DEP), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .raw_data(raw_data),
        .out_ready(out_ready), .aligned_valid(aligned_valid), .aligned_data(aligned_data),
        .row_count(row_count), .batch_done(batch_done),
`ifdef ALIGN_CHECK_EN
        .skew_err(skew_err),
`endif
        .overflow(overflow)
    );

    int           issue_row [NCY];
    bit           ready_at  [NCY];
    bit           reset_at  [NCY];
    logic [N-1:0] wh        [MAXR];
    logic [W-1:0] row_d     [MAXR][N];
    int           nrows = 0;

    int total = 0;
    int bad   = 0;
    logic [N*W-1:0] exp_q [$];

    int          occ = 0;
    logic [CW-1:0] rc = '0;
    bit          ovf = 0, skew = 0, prev_fire = 0, pend_clear = 0;
    int          last_rst = -1;

    bit            running = 0;
    bit            e_valid, e_bd, e_ovf, e_skew, e_zero;
    logic [CW-1:0] e_rc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add_row(input int t, input int base, input bit rnd);
        issue_row[t] = nrows;
        wh[nrows] = '0;
        for (int c = 0; c < N; c++)
            row_d[nrows][c] = rnd ? W'($urandom) : W'(base + c);
        nrows++;
    endtask

    function automatic logic [N*W-1:0] pack(input int id);
        logic [N*W-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = row_d[id][c];
        return v;
    endfunction

    // Monitor: compares visible outputs against the model and pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (running) begin
                check("aligned_valid", 64'(aligned_valid), 64'(e_valid));
                if (aligned_valid && e_valid) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL aligned_data: got %h want <no row expected>", aligned_data);
                    end else begin
                        check("aligned_data", 64'(aligned_data), 64'(exp_q[0]));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                check("row_count", 64'(row_count), 64'(e_rc));
                check("batch_done", 64'(batch_done), 64'(e_bd));
                check("overflow", 64'(overflow), 64'(e_ovf));
`ifdef ALIGN_CHECK_EN
                check("skew_err", 64'(skew_err), 64'(e_skew));
`endif
                if (e_zero) check("data_after_reset", 64'(aligned_data), 64'(0));
            end
        end
    end

    initial begin
        int t, fi, id, i;
        bit pop, pushreq;
        logic [N-1:0] dv;

        reset = 1'b1; out_ready = 1'b0; valid_in = '0; raw_data = '0;
        for (int n = 0; n < NCY; n++) begin
            issue_row[n] = -1; ready_at[n] = 1'b1; reset_at[n] = 1'b0;
        end

        t = 0;
        add_row(0, 16'h10, 0);
        t = 10;
        for (int r = 0; r < 8; r++) add_row(t + r, 16'h100 * r, 0);
        t += 16;
        for (int n = t; n < t + 10; n++) ready_at[n] = 1'b0;
        for (int r = 0; r < 6; r++) add_row(t + r, 16'h100 * r, 0);
        reset_at[t + 16] = 1'b1;
        t += 18;
        for (int n = t; n < t + 11; n++) ready_at[n] = 1'b0;
        ready_at[t + 9] = 1'b1;
        for (int r = 0; r < 4; r++) add_row(t + r, 16'h100 * r + 16'h40, 0);
        add_row(t + 6, 16'h4400, 0);
        t += 18;
        for (int r = 0; r < 6; r++) add_row(t + r, 16'h100 * r + 16'h80, 0);
        reset_at[t + 2] = 1'b1;
        t += 12;
        for (int r = 0; r < 4; r++) add_row(t + r, 16'h100 * r + 16'hA0, 0);
        wh[nrows - 2] = 4'b0100;
        t += 10;
        reset_at[t] = 1'b1;
        t += 2;
        while (t < NCY - 12) begin
            if ($urandom % 10 < 6) begin
                add_row(t, 0, 1);
                if ($urandom % 20 == 0) wh[nrows - 1] = N'(1 << (1 + $urandom % (N - 1)));
            end
            ready_at[t] = 1'($urandom % 2);
            if ($urandom % 100 == 0) reset_at[t] = 1'b1;
            t++;
        end

        repeat (2) @(posedge clk);
        running = 1'b1;
        for (int n = 0; n < NCY; n++) begin
            @(posedge clk);
            #1;
            if (pend_clear) begin
                exp_q.delete();
                pend_clear = 1'b0;
            end
            reset     = reset_at[n];
            out_ready = ready_at[n];
            for (int c = 0; c < N; c++) begin
                i  = n - c;
                id = (i >= 0) ? issue_row[i] : -1;
                if (id >= 0) begin
                    valid_in[c]       = !wh[id][c];
                    raw_data[c*W +: W] = row_d[id][c];
                end else begin
                    valid_in[c]       = 1'b0;
                    raw_data[c*W +: W] = W'($urandom);
                end
            end

            fi = (n >= N - 1) ? issue_row[n - (N - 1)] : -1;
            for (int c = 0; c < N; c++)
                dv[c] = (fi >= 0) && ((n - (N - 1) + c) > last_rst) && !wh[fi][c];

            e_valid = (occ > 0);
            e_rc    = rc;
            e_ovf   = ovf;
            e_skew  = skew;
            e_bd    = prev_fire && !dv[0];
            e_zero  = (n > 0) && reset_at[n - 1];

            if (reset_at[n]) begin
                occ = 0; rc = '0; ovf = 0; skew = 0; prev_fire = 0;
                pend_clear = 1'b1;
                last_rst = n;
            end else begin
                pop     = (occ > 0) && ready_at[n];
                pushreq = dv[0] && (!CHK || (&dv));
                if (CHK && ((dv[0] && !(&dv)) || ((|dv[N-1:1]) && !dv[0]))) skew = 1'b1;
                if (pushreq) begin
                    if (occ < DEP || pop) begin
                        exp_q.push_back(pack(fi));
                        rc = rc + 1'b1;
                        occ++;
                    end else begin
                        ovf = 1'b1;
                    end
                end
                if (pop) occ--;
                if (e_bd) rc = '0;
                prev_fire = dv[0];
            end
        end
        @(posedge clk);
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
